// File: rtl/ysyx_25040129_wbq.sv
// ---------------------------------------------------------------------------
// ysyx_25040129_wbq -- write-back queue between the LSU and the GPR/CSR write
// ports. It buffers up to DEPTH completed results (valid/ready on the LSU
// side) and retires them in order, one per cycle, whenever wb_stall is low.
// It also exports a mask of GPRs that queued entries will write, for hazard
// detection, and a count of retired entries.
//
// Optional feature: define WBQ_BYPASS_EN to let a result arriving at an empty,
// unstalled queue go straight to the write ports in the same cycle.
//
// Ports
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   LSU handshake; enqueue on in_valid && in_ready
//   in_rd, in_result      destination GPR and value to write
//   in_csr_addr           destination CSR
//   in_csr_write          entry writes the CSR
//   in_reg_write          entry writes the GPR
//   wb_stall              1 = do not retire this cycle
//   reg_write_out, rd_out GPR write strobe and index
//   result_out            write data (GPR and CSR)
//   csr_write_out         CSR write strobe
//   csr_addr_out          CSR address
//   pending_mask          bit r set: a queued entry will write GPR r
//   count                 occupied entries
//   retire_cnt            entries retired since reset (wraps)
// ---------------------------------------------------------------------------
module ysyx_25040129_wbq #(
    parameter int REGS_DIG = 5,
    parameter int CSR_DIG  = 12,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REGS_DIG-1:0]       in_rd,
    input  logic [DATA_W-1:0]         in_result,
    input  logic [CSR_DIG-1:0]        in_csr_addr,
    input  logic                      in_csr_write,
    input  logic                      in_reg_write,
    input  logic                      wb_stall,
    output logic                      reg_write_out,
    output logic [REGS_DIG-1:0]       rd_out,
    output logic [DATA_W-1:0]         result_out,
    output logic                      csr_write_out,
    output logic [CSR_DIG-1:0]        csr_addr_out,
    output logic [2**REGS_DIG-1:0]    pending_mask,
    output logic [$clog2(DEPTH):0]    count,
    output logic [31:0]               retire_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage
    logic [REGS_DIG-1:0] rd_q       [DEPTH];
    logic [DATA_W-1:0]   res_q      [DEPTH];
    logic [CSR_DIG-1:0]  csr_addr_q [DEPTH];
    logic                csr_wr_q   [DEPTH];
    logic                reg_wr_q   [DEPTH];
    logic                valid_q    [DEPTH];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   retire_cnt_q, retire_cnt_d;

    logic full;
    logic drain;
    logic bypass;
    logic push;

    assign full  = (count_q == CW'(DEPTH));
    assign drain = (count_q != '0) && !wb_stall;

    // Ready may depend combinationally on wb_stall: a full queue that drains
    // this cycle can take a new entry at the same edge.
    assign in_ready = !full || drain;

`ifdef WBQ_BYPASS_EN
    // Gated by reset_n so no write strobe escapes while reset is asserted.
    assign bypass = reset_n && (count_q == '0) && in_valid && !wb_stall;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry is consumed directly and never stored.
    assign push = in_valid && in_ready && !bypass;

    always_comb begin
        count_d = count_q;
        if (push && !drain) begin
            count_d = count_q + CW'(1);
        end else if (!push && drain) begin
            count_d = count_q - CW'(1);
        end
    end

    assign retire_cnt_d = retire_cnt_q + {31'd0, (drain || bypass)};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            retire_cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rd_q[i]       <= '0;
                res_q[i]      <= '0;
                csr_addr_q[i] <= '0;
                csr_wr_q[i]   <= 1'b0;
                reg_wr_q[i]   <= 1'b0;
                valid_q[i]    <= 1'b0;
            end
        end else begin
            if (drain) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PW'(1);
            end
            // Placed after the drain clear: when full, wr_ptr == rd_ptr and
            // the incoming entry must win the valid bit.
            if (push) begin
                valid_q[wr_ptr_q]    <= 1'b1;
                rd_q[wr_ptr_q]       <= in_rd;
                res_q[wr_ptr_q]      <= in_result;
                csr_addr_q[wr_ptr_q] <= in_csr_addr;
                csr_wr_q[wr_ptr_q]   <= in_csr_write;
                reg_wr_q[wr_ptr_q]   <= in_reg_write;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            count_q      <= count_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Head (or bypassed input) drives the write ports. x0 never gets a GPR
    // strobe, but its CSR side effect still goes out.
    always_comb begin
        rd_out        = rd_q[rd_ptr_q];
        result_out    = res_q[rd_ptr_q];
        csr_addr_out  = csr_addr_q[rd_ptr_q];
        reg_write_out = drain && reg_wr_q[rd_ptr_q] && (rd_q[rd_ptr_q] != '0);
        csr_write_out = drain && csr_wr_q[rd_ptr_q];
        if (bypass) begin
            rd_out        = in_rd;
            result_out    = in_result;
            csr_addr_out  = in_csr_addr;
            reg_write_out = in_reg_write && (in_rd != '0);
            csr_write_out = in_csr_write;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && reg_wr_q[i] && (rd_q[i] != '0)) begin
                pending_mask[rd_q[i]] = 1'b1;
            end
        end
    end

    assign count      = count_q;
    assign retire_cnt = retire_cnt_q;

endmodule
